// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared control definitions for the fetch front end and the hazard unit.
//   Contents:
//     WAIT_CNT_W     width of the fetch wait (timeout) counter
//     fetch_state_t  fetch sequencer FSM states
//     redir_t        redirect request encoding (none / branch / jump)
//     redir_decode   priority encoder: jump wins over branch
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'b00,
        REDIR_BRANCH = 2'b01,
        REDIR_JUMP   = 2'b10
    } redir_t;

    // Jump has priority over branch when ID raises both in the same cycle.
    function automatic redir_t redir_decode(input logic jump, input logic branch);
        redir_t r;
        r = REDIR_NONE;
        if (jump) begin
            r = REDIR_JUMP;
        end else if (branch) begin
            r = REDIR_BRANCH;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// -----------------------------------------------------------------------------
// fetch_wait_counter
//   Saturating up-counter used to detect an instruction memory that never
//   answers. Counts enabled cycles, stops at 'limit', and flags 'timeout'
//   while the count sits at the limit.
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-low reset (count -> 0)
//   clear    in   synchronous clear, dominates enable
//   enable   in   count this cycle
//   limit    in   saturation value
//   timeout  out  count == limit
// -----------------------------------------------------------------------------
module fetch_wait_counter
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             timeout
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!reset || clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != limit)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign timeout = (cnt_q == limit);

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Front-end fetch control. Drives the PC write enable and branch/jump mux
//   selects, issues one instruction-memory fetch at a time, holds the fetched
//   word until ID accepts it, and squashes fetches made stale by a redirect.
//
//   Optional feature (compile-time macro FETCH_PERF_EN): adds free-running
//   performance counters perf_fetches / perf_stalls / perf_squashes.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   pc_current        current PC from the PC datapath
//   pc_write          1-cycle pulse: PC loads its next-address mux output
//   sel_branch        branch mux select (meaningful while pc_write=1)
//   sel_jump          jump mux select   (meaningful while pc_write=1)
//   imem_req          fetch request, held until imem_ack
//   imem_addr         fetch address, stable while imem_req=1
//   imem_ack          memory returns imem_rdata this cycle
//   imem_rdata        instruction word from memory
//   if_valid          if_instr / if_pc valid towards ID
//   if_instr, if_pc   fetched word and its address
//   id_ready          ID accepts when if_valid & id_ready
//   branch_taken      redirect request from ID, held until redirect_ack
//   jump_taken        redirect request from ID, held until redirect_ack
//   redirect_ack      1-cycle pulse: redirect applied to the PC
//   fetch_timeout     sticky: memory did not answer within TIMEOUT_CYC cycles
//   perf_*            (FETCH_PERF_EN only) accepted / stalled / dropped counts
// -----------------------------------------------------------------------------
module fetch_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_current,
    output logic              pc_write,
    output logic              sel_branch,
    output logic              sel_jump,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready,
    input  logic              branch_taken,
    input  logic              jump_taken,
    output logic              redirect_ack,
    output logic              fetch_timeout
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetches,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_squashes
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(TIMEOUT_CYC);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              fetch_timeout_q, fetch_timeout_d;

    redir_t            redir;
    logic              redir_pending;
    logic              apply_redir;   // redirect goes to the PC this cycle
    logic              advance_pc;    // sequential PC+4 after a good fetch
    logic              word_drop;     // a fetched/held word is discarded
    logic              word_accept;   // ID takes the held word
    logic              hold_stall;    // word held, ID not ready
    logic              waiting;       // memory request outstanding
    logic              wait_timeout;

    assign redir         = redir_decode(jump_taken, branch_taken);
    assign redir_pending = (redir != REDIR_NONE);

    // -------------------------------------------------------------------------
    // FSM next state, datapath captures and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        if_valid_d  = if_valid_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        apply_redir = 1'b0;
        advance_pc  = 1'b0;
        word_drop   = 1'b0;
        word_accept = 1'b0;
        hold_stall  = 1'b0;

        case (state_q)
            IDLE: begin
                if (redir_pending) begin
                    apply_redir = 1'b1;
                end else begin
                    state_d     = FETCH;
                    imem_addr_d = pc_current;
                end
            end

            FETCH: begin
                if (imem_ack) begin
                    if (redir_pending) begin
                        // Word belongs to the wrong path; redirect wins.
                        apply_redir = 1'b1;
                        word_drop   = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = imem_addr_q;
                        if_valid_d = 1'b1;
                        advance_pc = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redir_pending) begin
                    // Cannot abandon the request mid-flight; wait it out.
                    state_d = SQUASH;
                end
            end

            HOLD: begin
                if (redir_pending) begin
                    // The redirecting instruction is already in ID, so the
                    // held word is on the wrong path whether or not ID is ready.
                    if_valid_d  = 1'b0;
                    apply_redir = 1'b1;
                    word_drop   = 1'b1;
                    state_d     = IDLE;
                end else if (id_ready) begin
                    // PC already advanced when the word was captured.
                    if_valid_d  = 1'b0;
                    word_accept = 1'b1;
                    imem_addr_d = pc_current;
                    state_d     = FETCH;
                end else begin
                    hold_stall = 1'b1;
                end
            end

            SQUASH: begin
                if (imem_ack) begin
                    apply_redir = 1'b1;
                    word_drop   = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (!reset) begin
            state_d     = IDLE;
            imem_addr_d = '0;
            if_valid_d  = 1'b0;
            if_instr_d  = '0;
            if_pc_d     = '0;
            apply_redir = 1'b0;
            advance_pc  = 1'b0;
            word_drop   = 1'b0;
            word_accept = 1'b0;
            hold_stall  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        imem_addr_q <= imem_addr_d;
        if_valid_q  <= if_valid_d;
        if_instr_q  <= if_instr_d;
        if_pc_q     <= if_pc_d;
    end

    // -------------------------------------------------------------------------
    // Memory wait watchdog
    // -------------------------------------------------------------------------
    assign waiting = reset && ((state_q == FETCH) || (state_q == SQUASH));

    fetch_wait_counter #(
        .CNT_W (WAIT_CNT_W)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (~waiting | imem_ack),
        .enable  (waiting & ~imem_ack),
        .limit   (TIMEOUT_LIM),
        .timeout (wait_timeout)
    );

    always_comb begin
        fetch_timeout_d = fetch_timeout_q | (wait_timeout & waiting);
        if (!reset) begin
            fetch_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        fetch_timeout_q <= fetch_timeout_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pc_write      = apply_redir | advance_pc;
    assign sel_jump      = apply_redir & (redir == REDIR_JUMP);
    assign sel_branch    = apply_redir & (redir == REDIR_BRANCH);
    assign redirect_ack  = apply_redir;
    assign imem_req      = waiting;
    assign imem_addr     = imem_addr_q;
    // A pending redirect kills the held word in the same cycle so ID never
    // accepts it.
    assign if_valid      = if_valid_q & ~redir_pending;
    assign if_instr      = if_instr_q;
    assign if_pc         = if_pc_q;
    // The current-cycle term makes the flag visible as soon as the limit is hit.
    assign fetch_timeout = fetch_timeout_q | (wait_timeout & waiting);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetches_q, perf_fetches_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_squashes_q, perf_squashes_d;

    always_comb begin
        perf_fetches_d  = perf_fetches_q + {31'd0, word_accept};
        perf_stalls_d   = perf_stalls_q + {31'd0, hold_stall};
        perf_squashes_d = perf_squashes_q + {31'd0, word_drop};
        if (!reset) begin
            perf_fetches_d  = '0;
            perf_stalls_d   = '0;
            perf_squashes_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        perf_fetches_q  <= perf_fetches_d;
        perf_stalls_q   <= perf_stalls_d;
        perf_squashes_q <= perf_squashes_d;
    end

    assign perf_fetches  = perf_fetches_q;
    assign perf_stalls   = perf_stalls_q;
    assign perf_squashes = perf_squashes_q;
`else
    logic unused_perf_strobes;
    assign unused_perf_strobes = ^{word_accept, hold_stall, word_drop};
`endif

    // ID must hold a redirect request until it sees redirect_ack.
    property p_redirect_held;
        @(posedge clk) disable iff (!reset)
            (redir_pending && !redirect_ack) |=> redir_pending;
    endproperty
    a_redirect_held: assert property (p_redirect_held);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] BR_TGT  = 32'h0000_0100;
    localparam logic [31:0] JMP_TGT = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_current = '0;
    logic        pc_write, sel_branch, sel_jump;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        id_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump_taken = 1'b0;
    logic        redirect_ack;
    logic        fetch_timeout;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetches, perf_stalls, perf_squashes;
`endif

    fetch_sequencer #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .reset(reset), .pc_current(pc_current),
        .pc_write(pc_write), .sel_branch(sel_branch), .sel_jump(sel_jump),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .id_ready(id_ready), .branch_taken(branch_taken),
        .jump_taken(jump_taken), .redirect_ack(redirect_ack),
        .fetch_timeout(fetch_timeout)
`ifdef FETCH_PERF_EN
        , .perf_fetches(perf_fetches), .perf_stalls(perf_stalls),
        .perf_squashes(perf_squashes)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: filled by the stimulus, drained by the monitor.
    logic [31:0] exp_fetch[$];   // address of each acked fetch
    logic [2:0]  exp_pcw[$];     // {sel_jump, sel_branch, redirect_ack} per pc_write
    logic [63:0] exp_if[$];      // {if_pc, if_instr} per accepted word
    int          acc_cyc[$];

    int cyc = 0, req_cnt = 0, pcw_cnt = 0, rack_cnt = 0, ifv_cnt = 0;
    logic        req_prev = 1'b0;
    logic [31:0] addr_prev = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ 32'h0000_5A5A;
    endfunction

    function automatic logic [127:0] outs_vec();
        return {25'd0, pc_write, sel_branch, sel_jump, imem_req, imem_addr, if_valid,
                if_instr, if_pc, redirect_ack, fetch_timeout};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // PC datapath model
    always @(posedge clk) begin
        if (!reset) pc_current <= '0;
        else if (pc_write) begin
            if (sel_jump)        pc_current <= JMP_TGT;
            else if (sel_branch) pc_current <= BR_TGT;
            else                 pc_current <= pc_current + 32'd4;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            cyc++;
            if (imem_req) req_cnt++;
            if (pc_write) pcw_cnt++;
            if (redirect_ack) rack_cnt++;
            if (if_valid) ifv_cnt++;
            if (imem_req && imem_ack) begin
                if (exp_fetch.size() == 0) unexpected("fetch_addr");
                else chk("fetch_addr", 128'(imem_addr), 128'(exp_fetch.pop_front()));
            end
            if (pc_write) begin
                if (exp_pcw.size() == 0) unexpected("pc_write");
                else chk("pc_write_sel", 128'({sel_jump, sel_branch, redirect_ack}),
                         128'(exp_pcw.pop_front()));
            end
            if (redirect_ack) chk("redirect_ack_pcw", 128'(pc_write), 128'(1'b1));
            if (if_valid && id_ready) begin
                acc_cyc.push_back(cyc);
                if (exp_if.size() == 0) unexpected("if_word");
                else chk("if_word", 128'({if_pc, if_instr}), 128'(exp_if.pop_front()));
            end
            if (imem_req && req_prev) chk("imem_addr_stable", 128'(imem_addr), 128'(addr_prev));
            req_prev  = imem_req;
            addr_prev = imem_addr;
        end else begin
            req_prev = 1'b0;
        end
    end

    // Memory responder: wait for a request, add lat cycles, ack for one cycle.
    task automatic mem_serve(input int lat);
        int n = 0;
        while (!imem_req && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) unexpected("mem_req_wait_expired");
        repeat (lat) begin @(posedge clk); #1; end
        imem_ack   = 1'b1;
        imem_rdata = word_of(imem_addr);
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int pcw0, ifv0, req0, rack0;
`ifdef FETCH_PERF_EN
    logic [31:0] st0, sq0;
`endif

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs_vec(), 128'd0);
`ifdef FETCH_PERF_EN
        chk("reset_perf", 128'({perf_fetches, perf_stalls, perf_squashes}), 128'd0);
`endif
        @(posedge clk); #1;
        reset    = 1'b1;
        id_ready = 1'b1;

        // 1: back-to-back sequential fetches, 1-cycle memory
        for (int i = 0; i < 4; i++) begin
            exp_fetch.push_back(32'(i * 4));
            exp_pcw.push_back(3'b000);
            exp_if.push_back({32'(i * 4), word_of(32'(i * 4))});
        end
        pcw0 = pcw_cnt; ifv0 = ifv_cnt;
        acc_cyc.delete();
        for (int i = 0; i < 4; i++) mem_serve(0);
        @(negedge clk); #1;
        chk("t1_pc_writes", 128'(pcw_cnt - pcw0), 128'(4));
        chk("t1_valid_cycles", 128'(ifv_cnt - ifv0), 128'(4));
        chk("t1_accepts", 128'(acc_cyc.size()), 128'(4));
        if (acc_cyc.size() == 4) chk("t1_rate", 128'(acc_cyc[3] - acc_cyc[0]), 128'(6));

        // 2: 3-cycle memory at 0x10
        exp_fetch.push_back(32'h10);
        exp_pcw.push_back(3'b000);
        exp_if.push_back({32'h10, word_of(32'h10)});
        pcw0 = pcw_cnt; req0 = req_cnt;
        mem_serve(2);
        id_ready = 1'b0;
        chk("t2_req_cycles", 128'(req_cnt - req0), 128'(3));
        chk("t2_pc_writes", 128'(pcw_cnt - pcw0), 128'(1));

        // 3: ID stalls for 4 cycles
`ifdef FETCH_PERF_EN
        st0 = perf_stalls;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_stable", 128'({if_valid, if_instr, if_pc, imem_req, pc_write}),
                128'({1'b1, word_of(32'h10), 32'h10, 1'b0, 1'b0}));
        end
        @(posedge clk); #1;
        id_ready = 1'b1;

        // 4: branch while fetching, memory answers two cycles later
        @(posedge clk); #1;
`ifdef FETCH_PERF_EN
        chk("t3_perf_stalls", 128'(perf_stalls - st0), 128'(4));
        sq0 = perf_squashes;
`endif
        chk("t4_fetch_started", 128'({imem_req, imem_addr}), 128'({1'b1, 32'h14}));
        exp_fetch.push_back(32'h14);
        exp_pcw.push_back(3'b011);
        ifv0 = ifv_cnt; rack0 = rack_cnt; pcw0 = pcw_cnt;
        branch_taken = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_squash_wait", 128'({imem_req, imem_addr, pc_write}), 128'({1'b1, 32'h14, 1'b0}));
        @(posedge clk); #1;
        imem_ack   = 1'b1;
        imem_rdata = word_of(32'h14);
        @(posedge clk); #1;
        imem_ack     = 1'b0;
        branch_taken = 1'b0;
        chk("t4_redirect_acks", 128'(rack_cnt - rack0), 128'(1));
        chk("t4_pc_writes", 128'(pcw_cnt - pcw0), 128'(1));
`ifdef FETCH_PERF_EN
        chk("t4_perf_squash", 128'(perf_squashes - sq0), 128'(1));
`endif

        // 5: jump + branch + ack together at 0x100
        @(posedge clk); #1;
        exp_fetch.push_back(BR_TGT);
        exp_pcw.push_back(3'b101);
        branch_taken = 1'b1;
        jump_taken   = 1'b1;
        imem_ack     = 1'b1;
        imem_rdata   = word_of(BR_TGT);
        @(posedge clk); #1;
        branch_taken = 1'b0;
        jump_taken   = 1'b0;
        imem_ack     = 1'b0;
        @(negedge clk); #1;
        chk("t5_idle", 128'({imem_req, if_valid}), 128'(0));
        chk("t4_t5_no_valid", 128'(ifv_cnt - ifv0), 128'(0));

        // 6: memory never answers at 0x200
        repeat (255) @(posedge clk);
        @(negedge clk);
        chk("t6_before_limit", 128'({fetch_timeout, imem_req, imem_addr}), 128'({1'b0, 1'b1, JMP_TGT}));
        @(negedge clk);
        chk("t6_at_limit", 128'(fetch_timeout), 128'(1));
        repeat (5) @(negedge clk);
        chk("t6_sticky", 128'({fetch_timeout, imem_req}), 128'(2'b11));

        // Reset mid-fetch, then a late ack
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_mid_fetch", outs_vec(), 128'd0);
        pcw0 = pcw_cnt;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        @(negedge clk);
        chk("late_ack_ignored", outs_vec(), 128'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_fetch.push_back(32'h0);
        exp_pcw.push_back(3'b000);
        exp_if.push_back({32'h0, word_of(32'h0)});
        mem_serve(0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("recover_pc_writes", 128'(pcw_cnt - pcw0), 128'(1));
        chk("sb_fetch_empty", 128'(exp_fetch.size()), 128'(0));
        chk("sb_pcw_empty", 128'(exp_pcw.size()), 128'(0));
        chk("sb_if_empty", 128'(exp_if.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
